// File: rtl/sd_pkg.sv
// Shared definitions for the SD card command path: FSM state encoding,
// completion status codes, packet geometry and the bit-serial CRC7 step.
package sd_pkg;

    localparam int SD_CMD_LEN = 48;
    localparam int SD_HDR_LEN = 40;
    localparam logic [6:0] SD_CRC7_POLY = 7'h09;

    localparam logic [1:0] SD_ST_OK      = 2'b00;
    localparam logic [1:0] SD_ST_CRCERR  = 2'b01;
    localparam logic [1:0] SD_ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CRC      = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_TX  = 3'd3,
        ST_WAIT_RSP = 3'd4,
        ST_DONE     = 3'd5
    } sd_state_e;

    // One MSB-first step of CRC7 (x^7 + x^3 + 1).
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 accumulator, one data bit per enabled cycle, MSB first.
// Shared between the command scheduler and the CMD-line transmitter.
module sd_crc7_serial
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_r;

    // CRC register: clear has priority over shifting in a new bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            crc_r <= 7'h00;
        end else if (clr) begin
            crc_r <= 7'h00;
        end else if (en) begin
            crc_r <= crc7_step(crc_r, din);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/sd_cmd_sched.sv
// SD command-path scheduler: round-robin arbitration between requesters,
// CRC7 generation over the 40-bit header, packet hand-off to the CMD-line
// transmitter and completion reporting. One command in flight at a time.
// Optional feature: define SD_CMD_TIMEOUT_EN to add a response timeout of
// TIMEOUT_CYC cycles (status 10); otherwise the response wait is unbounded.
module sd_cmd_sched
    import sd_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [6*NUM_REQ-1:0]    req_idx,
    input  logic [32*NUM_REQ-1:0]   req_arg,
    input  logic [NUM_REQ-1:0]      req_rsp_exp,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [1:0]              status,
    output logic [SD_CMD_LEN-1:0]   cmdPkt,
    output logic                    newCmdStrb,
    input  logic                    tx_ready,
    input  logic                    tx_done,
    input  logic                    rsp_valid,
    input  logic                    rsp_crc_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [5:0] LAST_BIT = 6'(SD_HDR_LEN - 1);

    sd_state_e               state_r;
    logic [PW-1:0]           ptr_r;
    logic [5:0]              idx_r;
    logic [31:0]             arg_r;
    logic                    rsp_exp_r;
    logic [5:0]              bit_cnt_r;
    logic [NUM_REQ-1:0]      gnt_r;
    logic [NUM_REQ-1:0]      done_r;
    logic [1:0]              status_r;
    logic [SD_CMD_LEN-1:0]   cmd_pkt_r;
    logic                    strb_r;

    logic [PW-1:0]           win_s;
    logic                    any_s;
    logic [NUM_REQ-1:0]      win_oh_s;
    logic [5:0]              sel_idx_s;
    logic [31:0]             sel_arg_s;
    logic                    sel_rsp_s;
    logic [PW-1:0]           ptr_next_s;
    logic [SD_HDR_LEN-1:0]   hdr_s;
    logic                    hdr_bit_s;
    logic                    crc_clr_s;
    logic                    crc_en_s;
    logic [6:0]              crc_s;

`ifdef SD_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]        tmo_cnt_r;
`else
    logic [31:0]             unused_tmo_s;
    assign unused_tmo_s = 32'(TIMEOUT_CYC);
`endif

    // Round-robin search starting at the priority pointer; first hit wins.
    always_comb begin
        logic [PW-1:0] cand;
        logic          hit;
        win_s = '0;
        any_s = 1'b0;
        cand  = '0;
        hit   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand  = PW'((int'(ptr_r) + i) % NUM_REQ);
            hit   = !any_s && req[cand];
            win_s = hit ? cand : win_s;
            any_s = any_s | hit;
        end
    end

    // Decode the winner into a one-hot grant and select its command fields.
    always_comb begin
        win_oh_s  = '0;
        sel_idx_s = 6'd0;
        sel_arg_s = 32'd0;
        sel_rsp_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_oh_s[i] = (win_s == PW'(i));
            sel_idx_s   = (win_s == PW'(i)) ? req_idx[6*i +: 6]   : sel_idx_s;
            sel_arg_s   = (win_s == PW'(i)) ? req_arg[32*i +: 32] : sel_arg_s;
            sel_rsp_s   = (win_s == PW'(i)) ? req_rsp_exp[i]      : sel_rsp_s;
        end
    end

    // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
    always_comb begin
        if (win_s == PW'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = win_s + PW'(1);
        end
    end

    // Header bit feed for the CRC: MSB first, indexed by the bit counter.
    always_comb begin
        hdr_s     = {1'b0, 1'b1, idx_r, arg_r};
        hdr_bit_s = hdr_s[LAST_BIT - bit_cnt_r];
        crc_clr_s = (state_r == ST_IDLE) && any_s;
        crc_en_s  = (state_r == ST_CRC);
    end

    sd_crc7_serial u_crc7 (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (crc_clr_s),
        .en      (crc_en_s),
        .din     (hdr_bit_s),
        .crc     (crc_s)
    );

    // Command FSM with registered grant, completion, status and packet outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            idx_r     <= 6'd0;
            arg_r     <= 32'd0;
            rsp_exp_r <= 1'b0;
            bit_cnt_r <= 6'd0;
            gnt_r     <= '0;
            done_r    <= '0;
            status_r  <= SD_ST_OK;
            cmd_pkt_r <= '0;
            strb_r    <= 1'b0;
`ifdef SD_CMD_TIMEOUT_EN
            tmo_cnt_r <= '0;
`endif
        end else begin
            strb_r <= 1'b0;
            done_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        idx_r     <= sel_idx_s;
                        arg_r     <= sel_arg_s;
                        rsp_exp_r <= sel_rsp_s;
                        gnt_r     <= win_oh_s;
                        bit_cnt_r <= 6'd0;
                        ptr_r     <= ptr_next_s;
                        state_r   <= ST_CRC;
                    end
                end
                ST_CRC: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        state_r <= ST_ISSUE;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                ST_ISSUE: begin
                    // CRC is final here; packet is rebuilt each ISSUE cycle and
                    // then held through the strobe and beyond.
                    cmd_pkt_r <= {1'b0, 1'b1, idx_r, arg_r, crc_s, 1'b1};
                    if (tx_ready) begin
                        strb_r  <= 1'b1;
                        state_r <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    // strb_r high means this is the strobe cycle: a tx_done
                    // here belongs to an earlier transfer and is ignored.
                    if (tx_done && !strb_r) begin
                        if (rsp_exp_r) begin
                            state_r <= ST_WAIT_RSP;
`ifdef SD_CMD_TIMEOUT_EN
                            tmo_cnt_r <= '0;
`endif
                        end else begin
                            done_r   <= gnt_r;
                            status_r <= SD_ST_OK;
                            gnt_r    <= '0;
                            state_r  <= ST_DONE;
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_valid) begin
                        done_r   <= gnt_r;
                        status_r <= rsp_crc_err ? SD_ST_CRCERR : SD_ST_OK;
                        gnt_r    <= '0;
                        state_r  <= ST_DONE;
`ifdef SD_CMD_TIMEOUT_EN
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) begin
                        done_r   <= gnt_r;
                        status_r <= SD_ST_TIMEOUT;
                        gnt_r    <= '0;
                        state_r  <= ST_DONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
`endif
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt        = gnt_r;
    assign done       = done_r;
    assign status     = status_r;
    assign cmdPkt     = cmd_pkt_r;
    assign newCmdStrb = strb_r;

endmodule

// File: tb/tb_sd_cmd_sched.sv
// Directed bench for sd_cmd_sched: hand-computed packets, strobe timing,
// round-robin order, response handling and reset recovery.
module tb_sd_cmd_sched;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req;
    logic [11:0] req_idx;
    logic [63:0] req_arg;
    logic [1:0]  req_rsp_exp;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  status;
    logic [47:0] cmdPkt;
    logic        newCmdStrb;
    logic        tx_ready;
    logic        tx_done;
    logic        rsp_valid;
    logic        rsp_crc_err;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cnt    = 0;

    localparam logic [47:0] PKT_CMD0 = 48'h400000000095;
    localparam logic [47:0] PKT_CMD8 = 48'h48000001AA87;

    sd_cmd_sched #(.NUM_REQ(2), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_idx     (req_idx),
        .req_arg     (req_arg),
        .req_rsp_exp (req_rsp_exp),
        .gnt         (gnt),
        .done        (done),
        .status      (status),
        .cmdPkt      (cmdPkt),
        .newCmdStrb  (newCmdStrb),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .rsp_valid   (rsp_valid),
        .rsp_crc_err (rsp_crc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":gnt"}, 48'(gnt), 48'd0);
        chk({tag, ":done"}, 48'(done), 48'd0);
        chk({tag, ":status"}, 48'(status), 48'd0);
        chk({tag, ":pkt"}, cmdPkt, 48'd0);
        chk({tag, ":strb"}, 48'(newCmdStrb), 48'd0);
    endtask

    // Arbitrate, run CRC, optionally hold tx_ready low, end in the strobe cycle.
    task automatic issue(input logic [1:0] exp_gnt, input logic [47:0] exp_pkt,
                         input int rdy_delay, input string tag);
        int bad;
        bad = 0;
        if (rdy_delay > 0) tx_ready = 1'b0;
        tick();
        chk({tag, ":gnt"}, 48'(gnt), 48'(exp_gnt));
        for (int i = 0; i < 40; i++) begin
            tick();
            if (newCmdStrb !== 1'b0 || gnt !== exp_gnt) bad++;
        end
        for (int i = 0; i < rdy_delay; i++) begin
            tick();
            if (newCmdStrb !== 1'b0) bad++;
        end
        chk({tag, ":early_strb_or_gnt"}, 48'(bad), 48'd0);
        tx_ready = 1'b1;
        tick();
        chk({tag, ":strb"}, 48'(newCmdStrb), 48'd1);
        chk({tag, ":pkt"}, cmdPkt, exp_pkt);
    endtask

    // Pulse tx_done for a no-response command; check completion, back to IDLE.
    task automatic complete_tx(input logic [1:0] exp_done, input string tag);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({tag, ":done"}, 48'(done), 48'(exp_done));
        chk({tag, ":status"}, 48'(status), 48'd0);
        chk({tag, ":gnt_off"}, 48'(gnt), 48'd0);
        tick();
        chk({tag, ":done_pulse"}, 48'(done), 48'd0);
    endtask

    // Pulse rsp_valid; check completion with the expected status.
    task automatic complete_rsp(input logic err, input logic [1:0] exp_done,
                                input logic [1:0] exp_st, input string tag);
        rsp_valid   = 1'b1;
        rsp_crc_err = err;
        tick();
        rsp_valid   = 1'b0;
        rsp_crc_err = 1'b0;
        chk({tag, ":done"}, 48'(done), 48'(exp_done));
        chk({tag, ":status"}, 48'(status), 48'(exp_st));
        chk({tag, ":gnt_off"}, 48'(gnt), 48'd0);
        tick();
        chk({tag, ":done_pulse"}, 48'(done), 48'd0);
    endtask

    // From the strobe cycle: one idle WAIT_TX cycle, then tx_done into WAIT_RSP.
    task automatic to_wait_rsp(input string tag);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({tag, ":no_done_at_tx"}, 48'(done), 48'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        req         = 2'b00;
        req_idx     = 12'd0;
        req_arg     = 64'd0;
        req_rsp_exp = 2'b00;
        tx_ready    = 1'b1;
        tx_done     = 1'b0;
        rsp_valid   = 1'b0;
        rsp_crc_err = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Requester 0: CMD0, arg 0, no response.
        req = 2'b01;
        issue(2'b01, PKT_CMD0, 0, "cmd0");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("cmd0:strb_single", 48'(newCmdStrb), 48'd0);
        chk("cmd0:txdone_in_strb_ignored", 48'(done), 48'd0);
        chk("cmd0:gnt_held", 48'(gnt), 48'd1);
        complete_tx(2'b01, "cmd0_done");
        req = 2'b00;
        tick();

        // Requester 1: CMD8, arg 0x1AA, response with CRC error.
        req_idx[11:6]  = 6'd8;
        req_arg[63:32] = 32'h000001AA;
        req_rsp_exp[1] = 1'b1;
        req = 2'b10;
        issue(2'b10, PKT_CMD8, 0, "cmd8");
        tick();
        rsp_valid   = 1'b1;
        rsp_crc_err = 1'b1;
        tick();
        rsp_valid   = 1'b0;
        rsp_crc_err = 1'b0;
        chk("cmd8:rsp_in_wait_tx_ignored", 48'(done), 48'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 2'b00) cnt++;
        end
        chk("cmd8:waits_rsp", 48'(cnt), 48'd0);
        complete_rsp(1'b1, 2'b10, 2'b01, "cmd8_done");
        req = 2'b00;

        // Both requesting continuously: grants alternate starting at 0.
        req_rsp_exp = 2'b00;
        req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            if (n % 2 == 0) begin
                issue(2'b01, PKT_CMD0, 0, "rr0");
                tick();
                complete_tx(2'b01, "rr0_done");
            end else begin
                issue(2'b10, PKT_CMD8, 0, "rr1");
                tick();
                complete_tx(2'b10, "rr1_done");
            end
        end
        req = 2'b00;
        tick();

        // tx_ready low for 10 ISSUE cycles delays the strobe by 10 cycles.
        req = 2'b01;
        issue(2'b01, PKT_CMD0, 10, "rdy");
        tick();
        chk("rdy:strb_single", 48'(newCmdStrb), 48'd0);
        complete_tx(2'b01, "rdy_done");
        req = 2'b00;
        tick();

        // Requester 0 now sends CMD8 expecting a response.
        req_idx[5:0]   = 6'd8;
        req_arg[31:0]  = 32'h000001AA;
        req_rsp_exp[0] = 1'b1;
        req = 2'b01;
`ifdef SD_CMD_TIMEOUT_EN
        issue(2'b01, PKT_CMD8, 0, "tmo");
        to_wait_rsp("tmo");
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done !== 2'b00) cnt++;
        end
        chk("tmo:no_early_done", 48'(cnt), 48'd0);
        tick();
        chk("tmo:done", 48'(done), 48'd1);
        chk("tmo:status", 48'(status), 48'd2);
        tick();
        issue(2'b01, PKT_CMD8, 0, "tmo_race");
        to_wait_rsp("tmo_race");
        for (int i = 0; i < 15; i++) tick();
        complete_rsp(1'b0, 2'b01, 2'b00, "tmo_race_done");
`else
        issue(2'b01, PKT_CMD8, 0, "notmo");
        to_wait_rsp("notmo");
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 2'b00 || gnt !== 2'b01) cnt++;
        end
        chk("notmo:still_waiting", 48'(cnt), 48'd0);
        complete_rsp(1'b0, 2'b01, 2'b00, "notmo_done");
`endif

        // Reset during CRC: outputs clear and pointer returns to 0.
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("rst_crc:gnt_before", 48'(gnt), 48'd1);
        reset_n = 1'b0;
        tick();
        chk_all_zero("rst_crc");
        reset_n = 1'b1;
        req = 2'b11;
        issue(2'b01, PKT_CMD8, 0, "after_rst");

        // Reset during WAIT_RSP: no stale packet, pointer back at 0.
        to_wait_rsp("rst_rsp");
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        req = 2'b00;
        tick();
        chk_all_zero("rst_rsp");
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (newCmdStrb !== 1'b0 || gnt !== 2'b00 || done !== 2'b00) cnt++;
        end
        chk("rst_rsp:quiet", 48'(cnt), 48'd0);
        req = 2'b11;
        tick();
        chk("rst_rsp:ptr0", 48'(gnt), 48'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
